tt_sweep_ctrl: RTL and testbench

Self-checking stimulus and capture stage for the lab's truth-table implementations (six mux-based realizations: channels 0-2 implement Table 1, channels 3-5 implement Table 2).
- Drives the shared A/B/C select inputs through all 8 combinations and supplies constant hi/lo rails.
- Samples all six outputs after a settle delay and builds the captured truth table per channel.
- Compares each channel against the expected table and reports pass/fail with a start/busy/done handshake.

---
 rtl/tt_sweep_ctrl.sv | 159 +++++++++++++++
 tb/tb_tt_sweep_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_sweep_ctrl.sv
// rtl/tt_sweep_ctrl.sv - truth-table sweep stimulus/capture/compare stage; optional macro TT_SWEEP_EARLY_ABORT_EN
module tt_sweep_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXP_T1        = 8'h96,
    parameter logic [7:0]  EXP_T2        = 8'h63
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [2:0]  abc,
    output logic        hi,
    output logic        lo,
    input  logic [5:0]  dut_out,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [5:0]  mismatch_mask,
    output logic [47:0] tt_cap
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETTLE = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Settle counter runs 0..SETTLE_CYCLES-1; the last value hands over to SAMPLE.
    localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

    state_t          r_state;
    state_t          w_next;
    logic [3:0]      r_cnt;
    logic [2:0]      r_abc;
    logic            r_busy;
    logic            r_pass;
    logic [5:0]      r_mask;
    logic [5:0][7:0] r_tt_cap;

    logic [5:0]      w_exp_bits;
    logic [5:0]      w_mis;
    logic            w_any_mis;
    logic [5:0][7:0] w_cap_next;

    assign hi            = 1'b1;
    assign lo            = 1'b0;
    assign abc           = r_abc;
    assign busy          = r_busy;
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;
    assign mismatch_mask = r_mask;
    assign tt_cap        = r_tt_cap;

    // Expected bit per channel at the current vector, and which channels disagree with it.
    always_comb begin
        w_exp_bits = {{3{EXP_T2[r_abc]}}, {3{EXP_T1[r_abc]}}};
        w_mis      = dut_out ^ w_exp_bits;
        w_any_mis  = |w_mis;
    end

    // Captured table with the current vector's bit replaced by each channel's output.
    always_comb begin
        w_cap_next = r_tt_cap;
        for (int ch = 0; ch < 6; ch++) begin
            w_cap_next[ch][r_abc] = dut_out[ch];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; the last vector always ends in DONE so abc never wraps.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (r_cnt == CNT_LAST) begin
                    w_next = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
`ifdef TT_SWEEP_EARLY_ABORT_EN
                if (w_any_mis || (r_abc == 3'd7)) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SETTLE;
                end
`else
                if (r_abc == 3'd7) begin
                    w_next = S_DONE;
                end else begin
                    w_next = S_SETTLE;
                end
`endif
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Sweep datapath: stimulus vector, settle count, capture, mismatch accumulation, result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= 4'd0;
            r_abc    <= 3'd0;
            r_busy   <= 1'b0;
            r_pass   <= 1'b0;
            r_mask   <= 6'd0;
            r_tt_cap <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_abc    <= 3'd0;
                        r_cnt    <= 4'd0;
                        r_busy   <= 1'b1;
                        r_tt_cap <= '0;
                        r_pass   <= 1'b0;
                        r_mask   <= 6'd0;
                    end
                end
                S_SETTLE: begin
                    r_cnt <= r_cnt + 4'd1;
                end
                S_SAMPLE: begin
                    r_tt_cap <= w_cap_next;
                    r_mask   <= r_mask | w_mis;
                    if (w_next == S_SETTLE) begin
                        r_abc <= r_abc + 3'd1;
                        r_cnt <= 4'd0;
                    end
                end
                S_DONE: begin
                    r_busy <= 1'b0;
                    r_pass <= (r_mask == 6'd0);
                end
                default: begin
                    r_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// tb/tb_tt_sweep_ctrl.sv - self-checking bench for tt_sweep_ctrl
module tb_tt_sweep_ctrl;

    localparam int          SETTLE = 2;
    localparam int          VLEN   = SETTLE + 1;
    localparam logic [7:0]  T1     = 8'h96;
    localparam logic [7:0]  T2     = 8'h63;
    localparam logic [47:0] IDEAL  = {T2, T2, T2, T1, T1, T1};

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [2:0]  abc;
    logic        hi;
    logic        lo;
    logic [5:0]  dut_out;
    logic        busy;
    logic        done;
    logic        pass;
    logic [5:0]  mismatch_mask;
    logic [47:0] tt_cap;

    int n_cmp = 0;
    int n_bad = 0;

    tt_sweep_ctrl #(
        .SETTLE_CYCLES(SETTLE),
        .EXP_T1       (T1),
        .EXP_T2       (T2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abc          (abc),
        .hi           (hi),
        .lo           (lo),
        .dut_out      (dut_out),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .mismatch_mask(mismatch_mask),
        .tt_cap       (tt_cap)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [47:0] tbls;
        bit          noise;
        bit          pulse;
        int          e_done;
        int          e_last;
        logic        e_pass;
        logic [5:0]  e_mask;
        logic [47:0] e_cap;
    } vec_t;

    vec_t vecs[4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [5:0] bits_at(input logic [47:0] t, input int v);
        logic [5:0] r;
        for (int ch = 0; ch < 6; ch++) r[ch] = t[ch*8 + v];
        return r;
    endfunction

    // Reference: what a sweep over channel tables t must report.
    task automatic model(input logic [47:0] t, output int e_done, output int e_last,
                         output logic e_pass, output logic [5:0] e_mask, output logic [47:0] e_cap);
        int first_bad = 8;
        bit aborted   = 1'b0;
        logic [47:0] ideal = IDEAL;
        for (int v = 0; v < 8; v++)
            for (int ch = 0; ch < 6; ch++)
                if (t[ch*8 + v] != ideal[ch*8 + v] && first_bad == 8) first_bad = v;
        e_mask = '0;
        e_cap  = '0;
`ifdef TT_SWEEP_EARLY_ABORT_EN
        if (first_bad < 8) begin
            aborted = 1'b1;
            e_last  = first_bad;
            e_done  = VLEN * (first_bad + 1) + 1;
            e_pass  = 1'b0;
            for (int ch = 0; ch < 6; ch++) begin
                e_mask[ch] = (t[ch*8 + first_bad] != ideal[ch*8 + first_bad]);
                for (int v = 0; v <= first_bad; v++) e_cap[ch*8 + v] = t[ch*8 + v];
            end
        end
`endif
        if (!aborted) begin
            e_last = 7;
            e_done = 8 * VLEN + 1;
            e_cap  = t;
            for (int ch = 0; ch < 6; ch++) e_mask[ch] = (t[ch*8 +: 8] != ideal[ch*8 +: 8]);
            e_pass = (e_mask == 6'd0);
        end
    endtask

    // One start pulse, then cycle-by-cycle checks up to two cycles past DONE.
    task automatic run_sweep(input string tag, input logic [47:0] t, input bit noise, input bit pulse,
                             input int e_done, input int e_last, input logic e_pass,
                             input logic [5:0] e_mask, input logic [47:0] e_cap);
        int n_done = 0;
        int vec;
        int ea;
        bit smp;
        @(posedge clk);
        #1;
        start   = 1'b1;
        dut_out = bits_at(t, 0);
        @(posedge clk);
        for (int c = 1; c <= e_done + 2; c++) begin
            #1;
            start = pulse && (c == 5 || c == e_done);
            vec   = (c - 1) / VLEN;
            if (vec > 7) vec = 7;
            smp   = ((c % VLEN) == 0) && (c <= 8 * VLEN);
            dut_out = bits_at(t, vec);
            if (noise && !smp) dut_out = 6'($urandom);
            @(negedge clk);
            if (done) n_done++;
            ea = (vec < e_last) ? vec : e_last;
            chk($sformatf("%s busy c%0d", tag, c), 64'(busy), 64'(c <= e_done));
            chk($sformatf("%s done c%0d", tag, c), 64'(done), 64'(c == e_done));
            chk($sformatf("%s abc c%0d", tag, c), 64'(abc), 64'(ea));
            if (c == e_done + 1) begin
                chk($sformatf("%s pass", tag), 64'(pass), 64'(e_pass));
                chk($sformatf("%s mask", tag), 64'(mismatch_mask), 64'(e_mask));
                chk($sformatf("%s tt_cap", tag), 64'(tt_cap), 64'(e_cap));
            end
            @(posedge clk);
        end
        chk($sformatf("%s done_count", tag), 64'(n_done), 64'd1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " abc"},  64'(abc), 64'd0);
        chk({tag, " busy"}, 64'(busy), 64'd0);
        chk({tag, " done"}, 64'(done), 64'd0);
        chk({tag, " pass"}, 64'(pass), 64'd0);
        chk({tag, " mask"}, 64'(mismatch_mask), 64'd0);
        chk({tag, " cap"},  64'(tt_cap), 64'd0);
        chk({tag, " hi"},   64'(hi), 64'd1);
        chk({tag, " lo"},   64'(lo), 64'd0);
    endtask

    initial begin
        int          m_done;
        int          m_last;
        logic        m_pass;
        logic [5:0]  m_mask;
        logic [47:0] m_cap;
        logic [47:0] t;
        int          rel;
        int          vec;

        rst_n   = 1'b0;
        start   = 1'b0;
        dut_out = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("por");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        vecs[0] = '{IDEAL, 1'b1, 1'b1, 25, 7, 1'b1, 6'b000000, IDEAL};
`ifdef TT_SWEEP_EARLY_ABORT_EN
        vecs[1] = '{{8'h73, 8'h73, T2, T1, T1, T1}, 1'b0, 1'b0, 16, 4, 1'b0, 6'b110000,
                    {8'h13, 8'h13, 8'h03, 8'h16, 8'h16, 8'h16}};
        vecs[2] = '{48'd0, 1'b1, 1'b0, 4, 0, 1'b0, 6'b111000, 48'd0};
`else
        vecs[1] = '{{8'h73, 8'h73, T2, T1, T1, T1}, 1'b0, 1'b0, 25, 7, 1'b0, 6'b110000,
                    {8'h73, 8'h73, T2, T1, T1, T1}};
        vecs[2] = '{48'd0, 1'b1, 1'b0, 25, 7, 1'b0, 6'b111111, 48'd0};
`endif
        vecs[3] = '{{T2, T2, T2, T1, T1, 8'h16}, 1'b1, 1'b0, 25, 7, 1'b0, 6'b000001,
                    {T2, T2, T2, T1, T1, 8'h16}};

        for (int i = 0; i < 4; i++) begin
            run_sweep($sformatf("vec%0d", i), vecs[i].tbls, vecs[i].noise, vecs[i].pulse,
                      vecs[i].e_done, vecs[i].e_last, vecs[i].e_pass, vecs[i].e_mask, vecs[i].e_cap);
        end

        // Reset in the middle of vector 3.
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int c = 1; c < 10; c++) begin
            dut_out = bits_at(IDEAL, (c - 1) / VLEN);
            @(posedge clk);
            #1;
        end
        dut_out = bits_at(IDEAL, 3);
        #2;
        chk("pre_rst abc", 64'(abc), 64'd3);
        chk("pre_rst busy", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("mid_rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model(IDEAL, m_done, m_last, m_pass, m_mask, m_cap);
        run_sweep("post_rst", IDEAL, 1'b0, 1'b0, m_done, m_last, m_pass, m_mask, m_cap);

        // start held high: relaunch on the first IDLE cycle after DONE.
        @(posedge clk);
        #1;
        start   = 1'b1;
        dut_out = bits_at(IDEAL, 0);
        @(posedge clk);
        for (int c = 1; c <= 51; c++) begin
            #1;
            rel = ((c - 1) % 26) + 1;
            vec = (rel - 1) / VLEN;
            if (vec > 7) vec = 7;
            dut_out = bits_at(IDEAL, vec);
            @(negedge clk);
            chk($sformatf("held done c%0d", c), 64'(done), 64'(c == 25 || c == 51));
            if (c == 26) chk("held busy relaunch", 64'(busy), 64'd0);
            if (c == 27) chk("held abc restart", 64'(abc), 64'd0);
            @(posedge clk);
        end
        #1;
        start = 1'b0;
        @(negedge clk);
        chk("held idle busy", 64'(busy), 64'd0);
        chk("held idle pass", 64'(pass), 64'd1);
        @(negedge clk);
        chk("held stays idle", 64'(busy), 64'd0);

        // Randomized channel tables against the reference.
        for (int r = 0; r < 20; r++) begin
            t = IDEAL;
            for (int ch = 0; ch < 6; ch++)
                if ($urandom_range(0, 1) == 1)
                    t[ch*8 +: 8] = t[ch*8 +: 8] ^ 8'($urandom & $urandom & $urandom);
            model(t, m_done, m_last, m_pass, m_mask, m_cap);
            run_sweep($sformatf("rnd%0d", r), t, 1'($urandom_range(0, 1)), 1'b0,
                      m_done, m_last, m_pass, m_mask, m_cap);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
